pool_stage_param: RTL and testbench
===================================

# pool_stage_param

Parametrised 2x2 stride-2 pooling stage that sits between a convolution layer's output stream and the next layer, replacing the fixed 6-channel, 8-bit, max-only C1 pooling path. It accepts NCH packed channels per pixel in raster order over an IN_W x IN_H frame and selects max or average pooling per frame. It provides valid/ready backpressure on both sides and raises an exact, count-based done pulse instead of an idle timeout.

## Interface
- NCH, 6: channels per pixel (1..16)
- DW, 8: unsigned bits per channel value
- IN_W, 28: input frame width; must be even, otherwise elaboration error
- IN_H, 28: input frame height; must be even, otherwise elaboration error
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- i_start  in  1  start-of-frame request; honoured only in IDLE
- i_mode  in  1  0 = max, 1 = average; latched on accepted i_start
- in_valid  in  1  input pixel valid
- in_data  in  NCH*DW  channel k at bits [k*DW +: DW]
- in_ready  out  1  pixel accepted when in_valid && in_ready
- out_valid  out  1  pooled pixel valid
- out_data  out  NCH*DW  pooled channels, same packing as in_data
- out_ready  in  1  downstream accept
- o_busy  out  1  high in RUN and FLUSH
- o_done  out  1  one-cycle pulse at end of frame
- o_out_row  out  $clog2(IN_H/2)  row index of the current out_data
- o_out_col  out  $clog2(IN_W/2)  column index of the current out_data

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on i_start. Clears row/col counters and latches i_mode.
  - RUN -> FLUSH on acceptance of pixel (IN_H-1, IN_W-1).
  - FLUSH -> DONE once out_valid is low or the output handshake completes that cycle.
  - DONE -> IDLE unconditionally after one cycle. o_done = (state == DONE).
- i_start is ignored outside IDLE. i_mode changes during a frame have no effect.
- Input column and row counters advance on each accepted pixel. The column wraps at IN_W-1 and increments the row.
- Per-channel datapath on accepted pixels:
  - Even column: hold the value in pair register P.
  - Odd column: form H = combine(P, in).
  - Even row, odd column: write H to line buffer LB[col/2]. LB has IN_W/2 entries per channel; no reset is needed.
  - Odd row, odd column: result = combine(LB[col/2], H), loaded into the output register.
- Combine rules:
  - Max mode: unsigned maximum, DW bits.
  - Average mode: partial sums are carried at DW+2 bits. Result = (a+b+c+d+2) >> 2, which rounds half up and cannot overflow.
- Output register:
  - out_data, o_out_row and o_out_col are loaded together and held stable while out_valid && !out_ready.
  - out_valid clears on the handshake unless a new result loads in the same cycle.
- Frame yield: exactly (IN_W/2)*(IN_H/2) output handshakes per frame.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 0, o_busy 0, o_done 0, o_out_row 0, o_out_col 0, state IDLE.
- in_ready = (state == RUN) && (!out_valid || out_ready). It is combinational from out_ready.
- Latency: out_valid rises the cycle after the accepting edge of the odd-row, odd-column pixel.
- Throughput: one pixel per cycle when out_ready is held high.
- Simultaneous output handshake and new result load: the new result replaces the old one, and out_valid stays 1.
- o_done asserts the cycle after the last output handshake; it asserts 2 cycles after it if the handshake occurs in RUN on the final pixel's cycle.
- Reset mid-frame: the next edge returns all outputs to their reset values and any partial frame is discarded. The next i_start begins a clean frame.

## Test plan
- Max mode, NCH=2, IN_W=IN_H=4, no stall. Stimulus: ch0 = r*4+c, ch1 = 255-ch0. Required: ch0 outputs 5, 7, 13, 15 and ch1 outputs 255, 253, 247, 245, in raster order with (row,col) = (0,0),(0,1),(1,0),(1,1). o_done fires once.
- Average mode, same frame. Required: ch0 outputs 3, 5, 11, 13. An all-255 frame yields 255 with no wrap.
- Backpressure: out_ready toggles 1-of-3 cycles with in_valid held high. Required: in_ready drops while out_valid && !out_ready, out_data stays stable, there are no lost or duplicated outputs, and the values match the no-stall run.
- Reset mid-frame: reset_n low for 1 cycle after 9 pixels. Required: all outputs at reset values next cycle. A following full 4x4 frame produces exactly 4 correct outputs.
- i_start pulses during RUN plus an i_mode flip mid-frame. Required: no restart, the latched mode is kept, and o_done fires exactly once.
- Defaults, 28x28 random frame with random in_valid gaps. Required: 196 outputs matching the reference model, o_out_row/o_out_col ending at 13/13, and a single o_done pulse.

Source files
------------

// File: rtl/pool_stage_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pool_stage_param_if                                              |
// | Pixel-in / pooled-pixel-out valid/ready stream bundle.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface pool_stage_param_if #(
    parameter int NCH = 6,
    parameter int DW  = 8
) ();
    logic                in_valid;
    logic                in_ready;
    logic [NCH*DW-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NCH*DW-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/pool_stage_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pool_stage_param                                                 |
// | 2x2 stride-2 max/average pooling over an NCH-channel raster.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pool_stage_param #(
    parameter int NCH  = 6,
    parameter int DW   = 8,
    parameter int IN_W = 28,
    parameter int IN_H = 28,
    localparam int ORW = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1,
    localparam int OCW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           i_start,
    input  wire logic           i_mode,
    pool_stage_param_if.slave   bus,
    output logic                o_busy,
    output logic                o_done,
    output logic [ORW-1:0]      o_out_row,
    output logic [OCW-1:0]      o_out_col
);
    localparam int CW     = $clog2(IN_W);
    localparam int RW     = $clog2(IN_H);
    localparam int SW     = DW + 2;
    localparam int HALF_W = IN_W / 2;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    generate
        if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_width
            $error("pool_stage_param: IN_W must be even and >= 2");
        end
        if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_height
            $error("pool_stage_param: IN_H must be even and >= 2");
        end
        if (NCH < 1 || NCH > 16) begin : g_bad_nch
            $error("pool_stage_param: NCH must be in 1..16");
        end
    endgenerate

    logic [1:0]                  state_q, state_d;
    logic                        mode_q, mode_d;
    logic [CW-1:0]               col_q, col_d;
    logic [RW-1:0]               row_q, row_d;
    logic [NCH-1:0][DW-1:0]      pair_q, pair_d;
    logic                        out_valid_q, out_valid_d;
    logic [NCH*DW-1:0]           out_data_q, out_data_d;
    logic [ORW-1:0]              out_row_q, out_row_d;
    logic [OCW-1:0]              out_col_q, out_col_d;

    // Horizontal partials carried at DW+2 bits so average sums never wrap
    logic [NCH-1:0][SW-1:0]      lb_mem [HALF_W];

    logic                        w_accept, w_col_wrap, w_last_pix, w_lb_we, w_load;
    logic [OCW-1:0]              w_lb_idx;
    logic [NCH-1:0][DW-1:0]      w_px, w_res;
    logic [NCH-1:0][SW-1:0]      w_h, w_lb_rd;

    assign bus.in_ready  = (state_q == c_run) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign o_busy        = (state_q == c_run) || (state_q == c_flush);
    assign o_done        = (state_q == c_done);
    assign o_out_row     = out_row_q;
    assign o_out_col     = out_col_q;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_col_wrap = (col_q == CW'(IN_W - 1));
    assign w_last_pix = w_col_wrap && (row_q == RW'(IN_H - 1));
    assign w_lb_we    = w_accept && col_q[0] && !row_q[0];
    assign w_load     = w_accept && col_q[0] && row_q[0];
    assign w_lb_idx   = OCW'(col_q >> 1);
    assign w_px       = bus.in_data;
    assign w_lb_rd    = lb_mem[w_lb_idx];

    always_comb begin
        w_h   = '0;
        w_res = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mode_q) begin
                w_h[k]   = SW'(pair_q[k]) + SW'(w_px[k]);
                w_res[k] = DW'((w_lb_rd[k] + w_h[k] + SW'(2)) >> 2);
            end else begin
                w_h[k]   = (w_px[k] > pair_q[k]) ? SW'(w_px[k]) : SW'(pair_q[k]);
                w_res[k] = (w_h[k] > w_lb_rd[k]) ? w_h[k][DW-1:0] : w_lb_rd[k][DW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;

        case (state_q)
            c_idle: begin
                if (i_start) begin
                    state_d = c_run;
                    mode_d  = i_mode;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            c_run:   if (w_accept && w_last_pix) state_d = c_flush;
            c_flush: if (!out_valid_q || bus.out_ready) state_d = c_done;
            c_done:  state_d = c_idle;
            default: state_d = c_idle;
        endcase

        if (w_accept) begin
            if (w_col_wrap) begin
                col_d = '0;
                row_d = w_last_pix ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) pair_d = w_px;
        end

        // A fresh result wins over retiring the one being handshaken
        if (w_load) begin
            out_valid_d = 1'b1;
            out_data_d  = w_res;
            out_row_d   = ORW'(row_q >> 1);
            out_col_d   = w_lb_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= c_idle;
            mode_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_lb_we) lb_mem[w_lb_idx] <= w_h;
    end
endmodule
`default_nettype wire

// File: tb/tb_pool_stage_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pool_stage_param                                              |
// | Directed/random frames against a 2x2 pooling reference model.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pool_stage_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] start;
    logic       mode_in;
    logic [1:0] busy, done;
    logic [0:0] row_s, col_s;
    logic [3:0] row_d, col_d;

    pool_stage_param_if #(.NCH(2), .DW(8)) bus_s ();
    pool_stage_param_if                     bus_d ();

    pool_stage_param #(.NCH(2), .DW(8), .IN_W(4), .IN_H(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .i_start(start[0]), .i_mode(mode_in), .bus(bus_s),
        .o_busy(busy[0]), .o_done(done[0]), .o_out_row(row_s), .o_out_col(col_s));

    pool_stage_param dut_d (
        .clk(clk), .reset_n(reset_n), .i_start(start[1]), .i_mode(mode_in), .bus(bus_d),
        .o_busy(busy[1]), .o_done(done[1]), .o_out_row(row_d), .o_out_col(col_d));

    logic [1:0]        ov, ordy, iry;
    logic [1:0][63:0]  od;
    logic [1:0][3:0]   orow, ocol;
    assign ov[0]   = bus_s.out_valid;  assign ov[1]   = bus_d.out_valid;
    assign ordy[0] = bus_s.out_ready;  assign ordy[1] = bus_d.out_ready;
    assign iry[0]  = bus_s.in_ready;   assign iry[1]  = bus_d.in_ready;
    assign od[0]   = 64'(bus_s.out_data); assign od[1] = 64'(bus_d.out_data);
    assign orow[0] = 4'(row_s);        assign orow[1] = row_d;
    assign ocol[0] = 4'(col_s);        assign ocol[1] = col_d;

    typedef struct { int row; int col; logic [63:0] data; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   pix [28][28][6];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   hs [2] = '{0, 0};
    int   dn [2] = '{0, 0};
    logic [1:0]       stall_prev = '0;
    logic [1:0][63:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected pooled pixels straight from the 2x2 window definition
    task automatic build_exp(input int w, input int h, input int n, input bit m);
        exp_t e;
        int a, b, c, d, v;
        for (int r = 0; r < h / 2; r++)
            for (int cc = 0; cc < w / 2; cc++) begin
                e.row = r; e.col = cc; e.data = '0;
                for (int k = 0; k < n; k++) begin
                    a = pix[2*r][2*cc][k];   b = pix[2*r][2*cc+1][k];
                    c = pix[2*r+1][2*cc][k]; d = pix[2*r+1][2*cc+1][k];
                    if (m) v = (a + b + c + d + 2) / 4;
                    else begin
                        v = a;
                        if (b > v) v = b;
                        if (c > v) v = c;
                        if (d > v) v = d;
                    end
                    e.data[k*8 +: 8] = v[7:0];
                end
                exp_q.push_back(e);
            end
    endtask

    task automatic fill(input int kind, input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int k = 0; k < 6; k++) begin
                    if (kind == 0) pix[r][c][k] = (k == 0) ? r * 4 + c : 255 - (r * 4 + c);
                    else if (kind == 1) pix[r][c][k] = 255;
                    else pix[r][c][k] = int'($urandom_range(255));
                end
    endtask

    function automatic logic rdy(input int md, input int c);
        if (md == 0) return 1'b1;
        if (md == 1) return (c % 3) == 0;
        return $urandom_range(3) != 0;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [63:0] d, input logic r);
        bus_s.in_valid  = (sel == 0) && v;
        bus_s.in_data   = d[15:0];
        bus_s.out_ready = (sel == 0) ? r : 1'b1;
        bus_d.in_valid  = (sel == 1) && v;
        bus_d.in_data   = d[47:0];
        bus_d.out_ready = (sel == 1) ? r : 1'b1;
    endtask

    task automatic chk_reset(input int sel);
        chk("rst_out_valid", 64'(ov[sel]), 0);
        chk("rst_out_data", od[sel], 0);
        chk("rst_in_ready", 64'(iry[sel]), 0);
        chk("rst_busy", 64'(busy[sel]), 0);
        chk("rst_done", 64'(done[sel]), 0);
        chk("rst_row", 64'(orow[sel]), 0);
        chk("rst_col", 64'(ocol[sel]), 0);
    endtask

    task automatic run_frame(input int sel, input bit m, input int rdy_mode,
                             input int gap_pct, input int stop_after, input bit spam);
        int w, h, n, total, p, cyc, hs0, dn0;
        logic [63:0] d;
        logic v, r;
        w = sel ? 28 : 4; h = w; n = sel ? 6 : 2; total = w * h;
        if (stop_after == 0) stop_after = total;
        build_exp(w, h, n, m);
        hs0 = hs[sel]; dn0 = dn[sel];
        @(posedge clk); #1; start[sel] = 1'b1; mode_in = m;
        @(posedge clk); #1; start = '0;
        chk("busy_after_start", 64'(busy[sel]), 1);
        p = 0; cyc = 0;
        while (p < stop_after) begin
            r = rdy(rdy_mode, cyc);
            v = $urandom_range(99) >= gap_pct;
            d = '0;
            for (int k = 0; k < n; k++) d[k*8 +: 8] = pix[p / w][p % w][k][7:0];
            set_in(sel, v, d, r);
            if (spam) begin
                start[sel] = (cyc % 5) == 2;
                mode_in    = ((cyc % 7) == 3) ? ~m : m;
            end
            @(negedge clk);
            if (v && iry[sel]) p++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 20000) begin
                chk("pixel_timeout", 64'(p), 64'(stop_after));
                break;
            end
        end
        start = '0; mode_in = m;
        set_in(sel, 1'b0, '0, 1'b1);
        if (stop_after < total) return;
        cyc = 0;
        while (dn[sel] == dn0 && cyc < 300) begin
            set_in(sel, 1'b0, '0, rdy(rdy_mode, cyc));
            @(posedge clk); #1;
            cyc++;
        end
        set_in(sel, 1'b0, '0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", 64'(dn[sel] - dn0), 1);
        chk("output_count", 64'(hs[sel] - hs0), 64'((w / 2) * (h / 2)));
        chk("exp_left", 64'(exp_q.size()), 0);
        chk("busy_idle", 64'(busy[sel]), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset_n) begin
                if (ov[s] && ordy[s]) begin
                    hs[s]++;
                    if (exp_q.size() == 0) chk("extra_output", 1, 0);
                    else begin
                        mon_e = exp_q.pop_front();
                        chk("out_data", od[s], mon_e.data);
                        chk("out_row", 64'(orow[s]), 64'(mon_e.row));
                        chk("out_col", 64'(ocol[s]), 64'(mon_e.col));
                    end
                end
                if (ov[s] && !ordy[s]) chk("in_ready_stall", 64'(iry[s]), 0);
                if (stall_prev[s]) chk("out_hold", od[s], held[s]);
                stall_prev[s] = ov[s] && !ordy[s];
                held[s]       = od[s];
                if (done[s]) dn[s]++;
            end else begin
                stall_prev[s] = 1'b0;
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = '0; mode_in = 1'b0;
        set_in(0, 1'b0, '0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        reset_n = 1'b1;

        fill(0, 4, 4);
        run_frame(0, 1'b0, 0, 0, 0, 1'b0);   // max, no stall
        run_frame(0, 1'b1, 0, 0, 0, 1'b0);   // average, same frame
        fill(1, 4, 4);
        run_frame(0, 1'b1, 0, 0, 0, 1'b0);   // all-255 average
        fill(0, 4, 4);
        run_frame(0, 1'b0, 1, 0, 0, 1'b0);   // 1-of-3 out_ready

        run_frame(0, 1'b0, 0, 0, 9, 1'b0);   // abandon after 9 pixels
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_reset(0);
        reset_n = 1'b1;
        exp_q.delete();
        run_frame(0, 1'b0, 0, 0, 0, 1'b0);

        fill(2, 4, 4);
        run_frame(0, 1'b1, 0, 0, 0, 1'b1);   // start/mode noise mid-frame
        run_frame(0, 1'b0, 2, 20, 0, 1'b1);

        fill(2, 28, 28);
        run_frame(1, 1'b0, 0, 30, 0, 1'b0);
        chk("final_row", 64'(orow[1]), 13);
        chk("final_col", 64'(ocol[1]), 13);
        fill(2, 28, 28);
        run_frame(1, 1'b1, 2, 25, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
